led_cnt_multi: RTL
==================

Name: led_cnt_multi

Overview:
- Multi-channel LED blink/pulse controller, the parametrised successor to the single-channel fixed-divider LED counter.
- Each of NUM_CH channels has a runtime-programmable mode and rate divider, loaded through a ready/valid write port.
- Half-period = CLK_HZ/div, computed by one shared iterative restoring divider rather than combinational division.
- Sits in the static/PR fabric region driving board LEDs; writes come from a PS-side register block.

Parameters:
- NUM_CH, 4, number of LED channels (1..16).
- CLK_HZ, 100000000, clock frequency; cycles per one-second count.
- DIV_W, 5, width of wr_div.
- DIV_MAX, 20, largest legal divider; 0 or >DIV_MAX is treated as 1.
- RST_MODE, 2, mode of every channel out of reset (0 OFF, 1 ON, 2 BLINK, 3 PULSE).

Ports:
- clk100  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request; accepted when wr_en && wr_ready.
- wr_ch  in  CH_W=max(1,$clog2(NUM_CH))  target channel; values >= NUM_CH are accepted and discarded.
- wr_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 PULSE.
- wr_div  in  DIV_W  rate divider.
- wr_ready  out  1  high when no divide is in progress.
- sync_i  in  1  phase-align all channels.
- led_o  out  NUM_CH  LED outputs, registered.

Behaviour:
- CNT_W = $clog2(CLK_HZ+1). Per-channel state: mode[1:0], cnt_max[CNT_W-1:0], cnt[CNT_W-1:0], led.
- Reset (rst_n low, async):
  - mode=RST_MODE, cnt_max=CLK_HZ, cnt=0, led=(RST_MODE==ON||RST_MODE==PULSE), hence led_o follows.
  - wr_ready=1; divider idle.
- Write path, shared divider:
  - Accept at edge E0: latch ch/mode; effective divisor d = (wr_div==0 || wr_div>DIV_MAX) ? 1 : wr_div; wr_ready=0 after E0.
  - Restoring divide of CLK_HZ by d, one quotient bit per edge, over edges E0+1..E0+CNT_W.
  - Commit on edge E0+CNT_W+1: channel cnt_max=quotient (remainder discarded), cnt=0, mode=new mode. led is 0 for OFF/BLINK and 1 for ON/PULSE.
  - wr_ready=1 after the commit edge, so it is low for exactly CNT_W+1 cycles.
  - Every mode uses the divider path; latency is uniform.
  - wr_en while wr_ready=0 is ignored (no queueing). Other channels run undisturbed during a divide.
- Per channel, each cycle:
  - OFF: led=0; cnt held at 0.
  - ON: led=1; cnt held at 0.
  - BLINK: if cnt==cnt_max then cnt=0, led=~led; else cnt+1. Toggle interval is cnt_max+1 cycles.
  - PULSE: if cnt==cnt_max then led=0, cnt=0, mode=OFF; else cnt+1. One high pulse of cnt_max+1 cycles.
- sync_i high: every channel's cnt=0. BLINK channels also set led=0; PULSE channels restart their count with led staying 1.
- Priority: reset > commit to a channel > sync_i > normal count. A commit coinciding with sync_i leaves that channel in the commit state, which is identical for cnt.
- Reset asserted mid-divide: divide aborted, no commit, all state takes reset values.
- cnt never exceeds cnt_max; a commit lowering cnt_max also zeroes cnt, so no wrap past max.

Optional Feature:
- LED_CNT_INV_EN defined: adds input led_inv_i [NUM_CH-1:0]; led_o = led ^ led_inv_i, combinational XOR after the register, no added latency. Used for active-low LED boards.
- Undefined: port absent; led_o = led.

Test Plan:
- Use CLK_HZ=100 (CNT_W=7), NUM_CH=4, RST_MODE=BLINK for all scenarios.
- Reset release -> all led_o=0, first toggle 101 cycles after rst_n rises, then every 101 cycles; wr_ready=1.
- Write ch1 BLINK div=3 -> wr_ready low 8 cycles. At commit: ch1 led=0, cnt_max=33. ch1 then toggles every 34 cycles; ch0/2/3 unaffected.
- Write ch2 div=0, then ch2 div=21 (BLINK) -> cnt_max=100 both times. Write wr_ch=5 (NUM_CH=4) -> 8-cycle busy, no channel changes.
- Write ch3 PULSE div=4 -> led_o[3] high exactly 26 cycles after commit, then 0 permanently, mode reads OFF.
- wr_en held during a busy window with different data -> only the first write commits. sync_i pulse -> all BLINK leds 0, cnt=0, next toggles aligned across channels.
- Drop rst_n 3 cycles into a divide -> immediate reset values, wr_ready=1, no commit after release.
- With LED_CNT_INV_EN, led_inv_i=4'b0101 -> led_o bits 0 and 2 inverted in the same cycle.

Source files
------------

// File: rtl/led_cnt_multi.sv
// led_cnt_multi: multi-channel LED blink/pulse controller with one shared iterative divider.
// Optional macro LED_CNT_INV_EN adds led_inv_i, XORed onto led_o after the output register.

module led_cnt_div #(
   parameter int CLK_HZ  = 100000000,
   parameter int DIV_W   = 5,
   parameter int DIV_MAX = 20,
   parameter int CH_W    = 2,
   parameter int CNT_W   = 27
) (
   input  logic             clk100,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [CH_W-1:0]  i_wr_ch,
   input  logic [1:0]       i_wr_mode,
   input  logic [DIV_W-1:0] i_wr_div,
   output logic             o_ready,
   output logic             o_commit,
   output logic [CH_W-1:0]  o_ch,
   output logic [1:0]       o_mode,
   output logic [CNT_W-1:0] o_quo
);
   // state    | meaning
   // S_IDLE   | ready, waiting for an accepted write
   // S_DIV    | one restoring quotient bit per edge, MSB first
   // S_COMMIT | quotient valid, o_commit loads the target channel this edge

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_COMMIT} state_t;

   localparam int STEP_W = $clog2(CNT_W + 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CNT_W - 1);
   localparam logic [CNT_W-1:0]  HZ_V      = CNT_W'(CLK_HZ);

   state_t             r_state;
   logic               r_ready;
   logic               r_commit;
   logic [STEP_W-1:0]  r_step;
   logic [DIV_W-1:0]   r_rem;
   logic [DIV_W-1:0]   r_div;
   logic [CNT_W-1:0]   r_dq;
   logic [CH_W-1:0]    r_ch;
   logic [1:0]         r_mode;

   logic [DIV_W-1:0]   w_div_eff;
   logic [DIV_W:0]     w_rsh;
   logic [DIV_W:0]     w_diff;
   logic [DIV_W:0]     w_rem_full;
   logic               w_ge;
   logic               w_unused;

   assign w_div_eff  = ((i_wr_div == '0) || (32'(i_wr_div) > DIV_MAX)) ? DIV_W'(1) : i_wr_div;

   // r_dq starts as the dividend and fills with quotient bits as it shifts left
   assign w_rsh      = {r_rem, r_dq[CNT_W-1]};
   assign w_ge       = (w_rsh >= {1'b0, r_div});
   assign w_diff     = w_rsh - {1'b0, r_div};
   assign w_rem_full = w_ge ? w_diff : w_rsh;
   assign w_unused   = w_rem_full[DIV_W];

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_ready  <= 1'b1;
         r_commit <= 1'b0;
         r_step   <= '0;
         r_rem    <= '0;
         r_div    <= '0;
         r_dq     <= '0;
         r_ch     <= '0;
         r_mode   <= '0;
      end else begin
         r_commit <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_wr_en) begin
                  r_state <= S_DIV;
                  r_ready <= 1'b0;
                  r_ch    <= i_wr_ch;
                  r_mode  <= i_wr_mode;
                  r_div   <= w_div_eff;
                  r_dq    <= HZ_V;
                  r_rem   <= '0;
                  r_step  <= STEP_LAST;
               end
            end
            S_DIV: begin
               r_dq  <= {r_dq[CNT_W-2:0], w_ge};
               r_rem <= w_rem_full[DIV_W-1:0];
               if (r_step == '0) begin
                  r_state  <= S_COMMIT;
                  r_commit <= 1'b1;
               end else begin
                  r_step <= r_step - STEP_W'(1);
               end
            end
            S_COMMIT: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ready  = r_ready;
   assign o_commit = r_commit;
   assign o_ch     = r_ch;
   assign o_mode   = r_mode;
   assign o_quo    = r_dq;
endmodule

module led_cnt_ch #(
   parameter int CLK_HZ   = 100000000,
   parameter int RST_MODE = 2,
   parameter int CNT_W    = 27
) (
   input  logic             clk100,
   input  logic             rst_n,
   input  logic             i_commit,
   input  logic [1:0]       i_mode,
   input  logic [CNT_W-1:0] i_cnt_max,
   input  logic             i_sync,
   output logic             o_led
);
   // state   | meaning
   // M_OFF   | led low, counter parked at 0
   // M_ON    | led high, counter parked at 0
   // M_BLINK | led toggles every cnt_max+1 cycles
   // M_PULSE | led high for cnt_max+1 cycles, then drops to M_OFF

   typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_PULSE = 2'd3} mode_t;

   localparam mode_t            RST_M   = mode_t'(2'(RST_MODE));
   localparam logic             RST_LED = (RST_MODE == 1) || (RST_MODE == 3);
   localparam logic [CNT_W-1:0] HZ_V    = CNT_W'(CLK_HZ);

   mode_t            r_mode;
   logic [CNT_W-1:0] r_cnt_max;
   logic [CNT_W-1:0] r_cnt;
   logic             r_led;
   logic             w_tc;

   assign w_tc = (r_cnt == r_cnt_max);

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_mode    <= RST_M;
         r_cnt_max <= HZ_V;
         r_cnt     <= '0;
         r_led     <= RST_LED;
      end else if (i_commit) begin
         r_mode    <= mode_t'(i_mode);
         r_cnt_max <= i_cnt_max;
         r_cnt     <= '0;
         r_led     <= (i_mode == M_ON) || (i_mode == M_PULSE);
      end else if (i_sync) begin
         // a running pulse restarts its full width with led still high
         r_cnt <= '0;
         if (r_mode == M_BLINK) r_led <= 1'b0;
      end else begin
         case (r_mode)
            M_OFF: begin
               r_led <= 1'b0;
               r_cnt <= '0;
            end
            M_ON: begin
               r_led <= 1'b1;
               r_cnt <= '0;
            end
            M_BLINK: begin
               if (w_tc) begin
                  r_cnt <= '0;
                  r_led <= ~r_led;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            M_PULSE: begin
               if (w_tc) begin
                  r_cnt  <= '0;
                  r_led  <= 1'b0;
                  r_mode <= M_OFF;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_mode <= M_OFF;
         endcase
      end
   end

   assign o_led = r_led;
endmodule

module led_cnt_multi #(
   parameter int NUM_CH   = 4,
   parameter int CLK_HZ   = 100000000,
   parameter int DIV_W    = 5,
   parameter int DIV_MAX  = 20,
   parameter int RST_MODE = 2,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W   = $clog2(CLK_HZ + 1)
) (
   input  logic              clk100,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [1:0]        wr_mode,
   input  logic [DIV_W-1:0]  wr_div,
   output logic              wr_ready,
   input  logic              sync_i,
`ifdef LED_CNT_INV_EN
   input  logic [NUM_CH-1:0] led_inv_i,
`endif
   output logic [NUM_CH-1:0] led_o
);
   logic              w_commit;
   logic [CH_W-1:0]   w_ch;
   logic [1:0]        w_mode;
   logic [CNT_W-1:0]  w_quo;
   logic [NUM_CH-1:0] w_led;

   led_cnt_div #(
      .CLK_HZ  (CLK_HZ),
      .DIV_W   (DIV_W),
      .DIV_MAX (DIV_MAX),
      .CH_W    (CH_W),
      .CNT_W   (CNT_W)
   ) u_div (
      .clk100    (clk100),
      .rst_n     (rst_n),
      .i_wr_en   (wr_en),
      .i_wr_ch   (wr_ch),
      .i_wr_mode (wr_mode),
      .i_wr_div  (wr_div),
      .o_ready   (wr_ready),
      .o_commit  (w_commit),
      .o_ch      (w_ch),
      .o_mode    (w_mode),
      .o_quo     (w_quo)
   );

   // a channel index >= NUM_CH matches no instance, so the write is dropped
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_commit_ch;
      assign w_commit_ch = w_commit && (w_ch == CH_W'(i));

      led_cnt_ch #(
         .CLK_HZ   (CLK_HZ),
         .RST_MODE (RST_MODE),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk100    (clk100),
         .rst_n     (rst_n),
         .i_commit  (w_commit_ch),
         .i_mode    (w_mode),
         .i_cnt_max (w_quo),
         .i_sync    (sync_i),
         .o_led     (w_led[i])
      );
   end

`ifdef LED_CNT_INV_EN
   assign led_o = w_led ^ led_inv_i;
`else
   assign led_o = w_led;
`endif
endmodule
